// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from a combinational instruction memory and
// hands each word to decode through a one-entry valid/ready output register.
module fetch_sequencer #(
   parameter logic [7:0] START_ADDR  = 8'h00,
   parameter logic [3:0] HALT_OPCODE = 4'hF,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       im_addr,
   input  logic [23:0]      im_instruction,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [23:0]      if_instr,
   output logic [7:0]       if_pc,
   input  logic             br_taken,
   input  logic [7:0]       br_target,
   output logic             halted,
   output logic             pc_wrap,
   output logic [CNT_W-1:0] fetch_count
);
   typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
   state_t           state_q, state_d;
   logic [7:0]       pc_q, pc_d, ipc_q, ipc_d;
   logic [23:0]      instr_q, instr_d;
   logic             valid_q, valid_d, wrap_q, wrap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hs;
   assign hs = valid_q & if_ready;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      wrap_d  = wrap_q;
      cnt_d   = cnt_q + CNT_W'(hs);
      case (state_q)
         IDLE: if (start) begin
            pc_d    = START_ADDR;
            state_d = FETCH;
         end
         FETCH: if (br_taken) begin
            pc_d    = br_target;
            valid_d = 1'b0;
         end else if (start) begin
            pc_d    = START_ADDR;
            valid_d = 1'b0;
         end else if (!valid_q || if_ready) begin
            instr_d = im_instruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            // A halt word is delivered but the PC parks on it
            if (im_instruction[23:20] == HALT_OPCODE) state_d = HALTED;
            else begin
               pc_d   = pc_q + 8'd1;
               wrap_d = wrap_q | (pc_q == 8'hFF);
            end
         end
         HALTED: if (start) begin
            pc_d    = START_ADDR;
            valid_d = 1'b0;
            state_d = FETCH;
         end else if (hs) valid_d = 1'b0;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         ipc_q   <= 8'h00;
         instr_q <= 24'h0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end
   assign im_addr     = pc_q;
   assign if_valid    = valid_q;
   assign if_instr    = instr_q;
   assign if_pc       = ipc_q;
   assign halted      = (state_q == HALTED);
   assign pc_wrap     = wrap_q;
   assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks of fetch_sequencer against a
// transaction-level reference model with its own instruction memory.
module tb_fetch_sequencer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, if_ready = 1'b0, br_taken = 1'b0;
   logic [7:0]  br_target = 8'h00, im_addr, if_pc;
   logic [23:0] im_instruction, if_instr;
   logic        if_valid, halted, pc_wrap;
   logic [15:0] fetch_count;
   logic [23:0] mem [256];
   int n_cmp = 0, n_err = 0;
   int          m_mode;
   int          m_pc, m_ipc;
   logic        m_v, m_wrap;
   logic [23:0] m_instr;
   logic [15:0] m_cnt;
   logic [58:0] obs;
   fetch_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .im_addr(im_addr), .im_instruction(im_instruction),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .br_taken(br_taken), .br_target(br_target), .halted(halted), .pc_wrap(pc_wrap),
      .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   assign im_instruction = mem[im_addr];
   assign obs = {im_addr, if_valid, if_instr, if_pc, halted, pc_wrap, fetch_count};
   function automatic logic [58:0] expv();
      return {8'(m_pc), m_v, m_instr, 8'(m_ipc), m_mode == 2, m_wrap, m_cnt};
   endfunction
   task automatic model_reset();
      m_mode = 0; m_pc = 0; m_ipc = 0; m_v = 0; m_wrap = 0; m_instr = 0; m_cnt = 0;
   endtask
   // Reference model: one delivery slot, PC advances mod 256, mode 0/1/2 = idle/fetch/halted
   task automatic model_edge();
      logic [23:0] w;
      if (rst) begin model_reset(); return; end
      if (m_v && if_ready) m_cnt = m_cnt + 16'd1;
      if (m_mode == 0) begin
         if (start) begin m_pc = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
         if (br_taken || start) begin m_pc = br_taken ? int'(br_target) : 0; m_v = 0; end
         else if (!m_v || if_ready) begin
            w = mem[m_pc];
            m_instr = w; m_ipc = m_pc; m_v = 1;
            if (w[23:20] == 4'hF) m_mode = 2;
            else begin
               if (m_pc == 255) m_wrap = 1;
               m_pc = (m_pc + 1) % 256;
            end
         end
      end else begin
         if (start) begin m_pc = 0; m_v = 0; m_mode = 1; end
         else if (m_v && if_ready) m_v = 0;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask
   task automatic fill_plain();
      for (int n = 0; n < 256; n++) mem[n] = {4'h1, 12'h0, 8'(n)};
   endtask
   task automatic test_reset();
      fill_plain();
      model_reset();
      rst = 1; step(); step();
      if (obs !== expv()) begin n_err++; $display("FAIL reset: got %h want %h", obs, expv()); end
      n_cmp++;
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         br_taken = 1'($urandom); br_target = 8'($urandom); if_ready = 1'($urandom);
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL idle[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      br_taken = 0;
   endtask
   task automatic test_stream();
      if_ready = 1; start = 1; step(); start = 0;
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_entry: if_valid got %b want 0", if_valid); end
      n_cmp++;
      for (int i = 0; i < 6; i++) begin
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL stream[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      if (if_pc !== 8'h05 || fetch_count !== 16'd5) begin
         n_err++; $display("FAIL stream_count: pc %h cnt %0d want 05/5", if_pc, fetch_count);
      end
      n_cmp++;
   endtask
   task automatic test_backpressure();
      rst = 1; step(); rst = 0;
      start = 1; if_ready = 1; step(); start = 0;
      for (int i = 0; i < 20 && !(m_v && m_ipc == 4); i++) step();
      if_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (obs !== expv() || if_pc !== 8'h04) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      if_ready = 1; step();
      if (if_pc !== 8'h05 || obs !== expv()) begin n_err++; $display("FAIL bp_release: got %h want %h", obs, expv()); end
      n_cmp++;
      for (int i = 0; i < 30; i++) begin
         if_ready = 1'($urandom);
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL bp_rand[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
   endtask
   task automatic test_branch();
      logic [15:0] c0;
      rst = 1; step(); rst = 0;
      start = 1; if_ready = 0; step(); start = 0;
      for (int i = 0; i < 20 && !(m_v && m_ipc == 6); i++) begin if_ready = 1; step(); end
      c0 = fetch_count;
      br_taken = 1; br_target = 8'h40; if_ready = 1; step(); br_taken = 0;
      if (if_valid !== 1'b0 || im_addr !== 8'h40 || fetch_count !== c0 + 16'd1) begin
         n_err++; $display("FAIL br_flush: v %b addr %h cnt %0d want 0/40/%0d", if_valid, im_addr, fetch_count, c0 + 16'd1);
      end
      n_cmp++;
      step();
      if (if_pc !== 8'h40 || if_valid !== 1'b1) begin n_err++; $display("FAIL br_target: pc %h v %b want 40/1", if_pc, if_valid); end
      n_cmp++;
      for (int i = 0; i < 60; i++) begin
         br_taken = ($urandom_range(0, 3) == 0); br_target = 8'($urandom);
         start = ($urandom_range(0, 15) == 0); if_ready = 1'($urandom);
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL br_rand[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      br_taken = 0; start = 0;
   endtask
   task automatic test_halt();
      rst = 1; step(); rst = 0;
      mem[3] = 24'hF00000;
      start = 1; if_ready = 1; step(); start = 0;
      for (int i = 0; i < 20 && !halted; i++) begin
         br_taken = 1'($urandom) & ($urandom_range(0, 3) == 0); br_target = 8'h00;
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL halt_run[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      br_taken = 0;
      if (halted !== 1'b1 || im_addr !== 8'h03 || if_instr !== 24'hF00000) begin
         n_err++; $display("FAIL halt_state: h %b addr %h instr %h want 1/03/F00000", halted, im_addr, if_instr);
      end
      n_cmp++;
      for (int i = 0; i < 5; i++) begin
         if_ready = 1'($urandom); br_taken = 1'($urandom); br_target = 8'($urandom);
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL halt_idle[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
      br_taken = 0; if_ready = 1; step();
      start = 1; step(); start = 0;
      if (halted !== 1'b0 || im_addr !== 8'h00 || if_valid !== 1'b0) begin
         n_err++; $display("FAIL halt_restart: h %b addr %h v %b want 0/00/0", halted, im_addr, if_valid);
      end
      n_cmp++;
      step();
      if (obs !== expv() || if_pc !== 8'h00) begin n_err++; $display("FAIL halt_resume: got %h want %h", obs, expv()); end
      n_cmp++;
      mem[3] = 24'h100003;
   endtask
   task automatic test_wrap_async();
      br_taken = 1; br_target = 8'hFE; if_ready = 1; step(); br_taken = 0;
      for (int i = 0; i < 10 && !(m_v && m_ipc == 255); i++) step();
      if (pc_wrap !== 1'b1 || if_pc !== 8'hFF || obs !== expv()) begin
         n_err++; $display("FAIL wrap_set: wrap %b pc %h want 1/FF", pc_wrap, if_pc);
      end
      n_cmp++;
      step();
      if (if_pc !== 8'h00 || pc_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_next: pc %h wrap %b want 00/1", if_pc, pc_wrap); end
      n_cmp++;
      #2 rst = 1; #1;
      if (obs !== 59'h0) begin n_err++; $display("FAIL async_reset: got %h want 0", obs); end
      n_cmp++;
      step(); rst = 0;
   endtask
   task automatic test_random();
      for (int n = 0; n < 256; n++) mem[n] = {4'($urandom_range(0, 14)), 20'($urandom)};
      for (int k = 0; k < 3; k++) mem[$urandom_range(1, 255)][23:20] = 4'hF;
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 19) == 0); br_taken = ($urandom_range(0, 7) == 0);
         br_target = 8'($urandom); if_ready = ($urandom_range(0, 3) != 0);
         step();
         if (obs !== expv()) begin n_err++; $display("FAIL rand[%0d]: got %h want %h", i, obs, expv()); end
         n_cmp++;
      end
   endtask
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_halt();
      test_wrap_async();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
